// File: rtl/fifo_to_multilane_bridge_if.sv
// Purpose: bundles the FIFO-side and lane-side signals of fifo_to_multilane_bridge.
//   master : bridge view (drives fifo_read, mode_lp, start_rqst, fin_rqst, inp_data, busy)
//   slave  : environment view (drives FIFO head, mode_lp_in, data_rqst, p2p_timeout)
// Parameters: LANES (1..4) lanes, TW gap counter width.
interface fifo_to_multilane_bridge_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TW    = 16
);
  localparam int unsigned BW = $clog2(LANES + 1);
  localparam int unsigned DW = 8 * LANES;

  logic [DW-1:0]    fifo_data;
  logic [BW-1:0]    fifo_bytes;
  logic             fifo_empty;
  logic             fifo_read;
  logic             mode_lp_in;
  logic             mode_lp;
  logic [LANES-1:0] start_rqst;
  logic [LANES-1:0] fin_rqst;
  logic [DW-1:0]    inp_data;
  logic             data_rqst;
  logic [TW-1:0]    p2p_timeout;
  logic             busy;

  modport master (
    input  fifo_data, fifo_bytes, fifo_empty, mode_lp_in, data_rqst, p2p_timeout,
    output fifo_read, mode_lp, start_rqst, fin_rqst, inp_data, busy
  );

  modport slave (
    output fifo_data, fifo_bytes, fifo_empty, mode_lp_in, data_rqst, p2p_timeout,
    input  fifo_read, mode_lp, start_rqst, fin_rqst, inp_data, busy
  );
endinterface

// File: rtl/fifo_to_multilane_bridge.sv
// Purpose: pulls LANES-byte words from a packet FIFO and presents one byte per
// lane to lockstep lane serialisers; issues per-lane start/finish requests,
// latches LP/HS mode per packet and enforces a programmable post-packet gap.
// Ports: clk, rst_n (async, active low), bus (master modport: FIFO head/pop,
// lane data/start/finish, data_rqst, p2p_timeout, mode, busy).
module fifo_to_multilane_bridge #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TW    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  fifo_to_multilane_bridge_if.master       bus
);
  localparam int unsigned BW = $clog2(LANES + 1);
  localparam int unsigned DW = 8 * LANES;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ACTIVE = 3'd2,
    S_FINISH = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    data_buf;
  logic [BW-1:0]    cnt;
  logic             mode_q;
  logic [TW-1:0]    gap_cnt;
  logic             pop;
  logic             word_full;
  logic [BW-1:0]    bytes_norm;
  logic [LANES-1:0] start_c;
  logic [LANES-1:0] fin_c;

  // Out-of-range byte counts (0 or >LANES) mean a full word.
  always_comb begin
    bytes_norm = bus.fifo_bytes;
    if (bus.fifo_bytes == '0 || bus.fifo_bytes > BW'(LANES)) begin
      bytes_norm = BW'(LANES);
    end
  end

  assign word_full = (cnt == BW'(LANES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!bus.fifo_empty) state_nxt = S_START;
      S_START:  state_nxt = S_ACTIVE;
      // A full word with more data queued keeps streaming; anything else ends the packet.
      S_ACTIVE: if (bus.data_rqst && !(word_full && !bus.fifo_empty)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = (bus.p2p_timeout != '0) ? S_GAP : S_IDLE;
      S_GAP:    if (gap_cnt <= TW'(1)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: pop strobe and per-lane start/finish requests.
  always_comb begin
    pop     = 1'b0;
    start_c = '0;
    fin_c   = '0;
    case (state)
      S_IDLE:   pop = !bus.fifo_empty;
      S_START:  start_c = '1;
      S_ACTIVE: begin
        // Lanes without a byte in this word terminate immediately.
        for (int k = 0; k < int'(LANES); k++) fin_c[k] = (k >= int'(cnt));
        pop = bus.data_rqst && word_full && !bus.fifo_empty;
      end
      S_FINISH: begin
        for (int k = 0; k < int'(LANES); k++) fin_c[k] = (k < int'(cnt));
      end
      default: ;
    endcase
  end

  // Word buffer, byte count, packet mode and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_buf <= '0;
      cnt      <= BW'(LANES);
      mode_q   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      if (pop) begin
        data_buf <= bus.fifo_data;
        cnt      <= bytes_norm;
        // Mode is latched only on the first word of a packet.
        if (state == S_IDLE) mode_q <= bus.mode_lp_in;
      end
      if (state == S_FINISH) begin
        gap_cnt <= bus.p2p_timeout;
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - TW'(1);
      end
    end
  end

  assign bus.fifo_read  = pop && rst_n;
  assign bus.start_rqst = start_c;
  assign bus.fin_rqst   = fin_c;
  assign bus.inp_data   = data_buf;
  assign bus.mode_lp    = mode_q;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_to_multilane_bridge.sv
// Purpose: self-checking bench for fifo_to_multilane_bridge (LANES=4). A FIFO
// model feeds the DUT; every queued word is also pushed to a scoreboard and
// popped/compared when the word appears on inp_data.
module tb_fifo_to_multilane_bridge;
  localparam int unsigned L  = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned BW = $clog2(L + 1);
  localparam int unsigned DW = 8 * L;
  localparam logic [L-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  fifo_to_multilane_bridge_if #(.LANES(L), .TW(TW)) bus ();

  fifo_to_multilane_bridge #(.LANES(L), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] n;
    logic          m;
  } ent_t;

  ent_t fq[$];
  ent_t sb[$];
  ent_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [BW-1:0] norm(input logic [BW-1:0] n);
    if (n == '0 || n > BW'(L)) return BW'(L);
    return n;
  endfunction

  function automatic logic [DW-1:0] bmask(input logic [BW-1:0] n);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < int'(L); k++) if (k < int'(n)) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [L-1:0] lanes_lo(input logic [BW-1:0] n);
    logic [L-1:0] m;
    m = '0;
    for (int k = 0; k < int'(L); k++) m[k] = (k < int'(n));
    return m;
  endfunction

  task automatic drive();
    if (fq.size() == 0) begin
      bus.fifo_empty = 1'b1;
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_data  = fq[0].d;
      bus.fifo_bytes = fq[0].n;
      bus.mode_lp_in = fq[0].m;
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [BW-1:0] n, input logic m);
    ent_t x;
    x.d = d; x.n = n; x.m = m;
    fq.push_back(x);
    x.n = norm(n);
    sb.push_back(x);
    drive();
  endtask

  // One clock: FIFO pops if fifo_read was high, then new inputs at the negedge.
  task automatic step(input logic drq);
    logic rd;
    #1;
    rd = bus.fifo_read;
    @(posedge clk);
    if (rd === 1'b1 && fq.size() > 0) fq.delete(0);
    @(negedge clk);
    drive();
    bus.data_rqst = drq;
    #1;
  endtask

  task automatic sb_pop();
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got no expected word, required one queued");
      e = '{d: '0, n: BW'(L), m: 1'b0};
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.start_rqst !== '0) begin errors++; $display("FAIL rst_start got %h exp 0", bus.start_rqst); end
    checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL rst_fin got %h exp 0", bus.fin_rqst); end
    checks++; if (bus.inp_data !== '0) begin errors++; $display("FAIL rst_inp got %h exp 0", bus.inp_data); end
    checks++; if (bus.mode_lp !== 1'b0) begin errors++; $display("FAIL rst_mode got %b exp 0", bus.mode_lp); end
    push(32'hAABBCCDD, 3'd4, 1'b1);
    #1;
    checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", bus.fifo_read); end
    fq.delete(); sb.delete(); drive();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_rel_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_single();
    bus.p2p_timeout = '0;
    push(32'h44332211, 3'd4, 1'b0);
    #1;
    checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL single_read got %b exp 1", bus.fifo_read); end
    step(1'b0);
    checks++; if (bus.start_rqst !== ALL) begin errors++; $display("FAIL single_start got %h exp %h", bus.start_rqst, ALL); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.busy); end
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL single_data got %h exp %h", bus.inp_data, e.d); end
    step(1'b1);
    checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL single_act_fin got %h exp 0", bus.fin_rqst); end
    checks++; if (bus.start_rqst !== '0) begin errors++; $display("FAIL single_act_start got %h exp 0", bus.start_rqst); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL single_fin got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", bus.busy); end
    checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL single_idle_fin got %h exp 0", bus.fin_rqst); end
  endtask

  task automatic test_burst();
    logic exp_rd;
    push(32'h13121110, 3'd4, 1'b0);
    push(32'h23222120, 3'd4, 1'b0);
    push(32'h33323130, 3'd4, 1'b0);
    #1;
    step(1'b0);
    checks++; if (bus.start_rqst !== ALL) begin errors++; $display("FAIL burst_start got %h exp %h", bus.start_rqst, ALL); end
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL burst_w0 got %h exp %h", bus.inp_data, e.d); end
    for (int w = 0; w < 3; w++) begin
      step(1'b0);
      if (w > 0) begin
        sb_pop();
        checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL burst_word%0d got %h exp %h", w, bus.inp_data, e.d); end
      end
      checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL burst_fin%0d got %h exp 0", w, bus.fin_rqst); end
      step(1'b1);
      exp_rd = (w < 2);
      checks++; if (bus.fifo_read !== exp_rd) begin errors++; $display("FAIL burst_pop%0d got %b exp %b", w, bus.fifo_read, exp_rd); end
    end
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL burst_finish got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL burst_fin_once got %h exp 0", bus.fin_rqst); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_idle got %b exp 0", bus.busy); end
  endtask

  task automatic test_short();
    push(32'h0D0C0B0A, 3'd4, 1'b0);
    push(32'hEEFF2211, 3'd2, 1'b0);
    #1;
    step(1'b0);
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL short_w0 got %h exp %h", bus.inp_data, e.d); end
    step(1'b1);
    checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL short_pop got %b exp 1", bus.fifo_read); end
    step(1'b0);
    sb_pop();
    checks++; if ((bus.inp_data & bmask(e.n)) !== (e.d & bmask(e.n))) begin errors++; $display("FAIL short_w1 got %h exp %h", bus.inp_data & bmask(e.n), e.d & bmask(e.n)); end
    checks++; if (bus.fin_rqst !== ~lanes_lo(e.n)) begin errors++; $display("FAIL short_level got %b exp %b", bus.fin_rqst, ~lanes_lo(e.n)); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== 4'b1100) begin errors++; $display("FAIL short_hold got %b exp 1100", bus.fin_rqst); end
    step(1'b1);
    checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL short_nopop got %b exp 0", bus.fifo_read); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== 4'b0011) begin errors++; $display("FAIL short_finish got %b exp 0011", bus.fin_rqst); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL short_idle got fin %b busy %b exp 0 0", bus.fin_rqst, bus.busy); end
  endtask

  task automatic test_gap();
    bus.p2p_timeout = TW'(5);
    push(32'h33221100, 3'd3, 1'b0);
    push(32'h77665544, 3'd4, 1'b0);
    #1;
    step(1'b0);
    sb_pop();
    checks++; if ((bus.inp_data & bmask(e.n)) !== (e.d & bmask(e.n))) begin errors++; $display("FAIL gap_a got %h exp %h", bus.inp_data & bmask(e.n), e.d & bmask(e.n)); end
    step(1'b1);
    checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL gap_short_nopop got %b exp 0", bus.fifo_read); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== 4'b0111) begin errors++; $display("FAIL gap_finish got %b exp 0111", bus.fin_rqst); end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0);
      if (i == 2) bus.p2p_timeout = TW'(1);
      checks++; if ({bus.busy, bus.fifo_read, bus.start_rqst} !== {1'b1, 1'b0, 4'h0}) begin errors++; $display("FAIL gap_cyc%0d got busy %b read %b start %h exp 1 0 0", i, bus.busy, bus.fifo_read, bus.start_rqst); end
    end
    step(1'b0);
    checks++; if (bus.fifo_read !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL gap_end got read %b busy %b exp 1 0", bus.fifo_read, bus.busy); end
    step(1'b0);
    checks++; if (bus.start_rqst !== ALL) begin errors++; $display("FAIL gap_start_b got %h exp %h", bus.start_rqst, ALL); end
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL gap_b got %h exp %h", bus.inp_data, e.d); end
    bus.p2p_timeout = '0;
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL gap_b_finish got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL gap_b_nogap got %b exp 0", bus.busy); end
  endtask

  task automatic test_mode();
    bus.p2p_timeout = '0;
    push(32'hA3A2A1A0, 3'd4, 1'b1);
    push(32'hB3B2B1B0, 3'd4, 1'b0);
    push(32'hC3C2C1C0, 3'd1, 1'b0);
    push(32'hD3D2D1D0, 3'd0, 1'b0);
    #1;
    step(1'b0);
    checks++; if (bus.mode_lp !== 1'b1) begin errors++; $display("FAIL mode_start got %b exp 1", bus.mode_lp); end
    sb_pop();
    step(1'b1);
    step(1'b1);
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL mode_w1 got %h exp %h", bus.inp_data, e.d); end
    checks++; if (bus.mode_lp !== 1'b1) begin errors++; $display("FAIL mode_hold1 got %b exp 1", bus.mode_lp); end
    step(1'b0);
    sb_pop();
    checks++; if ((bus.inp_data & bmask(e.n)) !== (e.d & bmask(e.n))) begin errors++; $display("FAIL mode_w2 got %h exp %h", bus.inp_data & bmask(e.n), e.d & bmask(e.n)); end
    checks++; if (bus.fin_rqst !== 4'b1110) begin errors++; $display("FAIL mode_level got %b exp 1110", bus.fin_rqst); end
    checks++; if (bus.mode_lp !== 1'b1) begin errors++; $display("FAIL mode_hold2 got %b exp 1", bus.mode_lp); end
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== 4'b0001) begin errors++; $display("FAIL mode_finish got %b exp 0001", bus.fin_rqst); end
    step(1'b0);
    step(1'b0);
    checks++; if (bus.mode_lp !== 1'b0) begin errors++; $display("FAIL mode_next got %b exp 0", bus.mode_lp); end
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL mode_w3 got %h exp %h", bus.inp_data, e.d); end
    step(1'b0);
    checks++; if (bus.fin_rqst !== '0) begin errors++; $display("FAIL mode_norm0 got %b exp 0000", bus.fin_rqst); end
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL mode_finish2 got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
  endtask

  task automatic test_reset_active();
    bus.p2p_timeout = '0;
    push(32'hDEADBEEF, 3'd4, 1'b1);
    push(32'h0BADF00D, 3'd4, 1'b1);
    #1;
    step(1'b0);
    sb_pop();
    step(1'b0);
    checks++; if (bus.mode_lp !== 1'b1) begin errors++; $display("FAIL rsta_pre_mode got %b exp 1", bus.mode_lp); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.fifo_read, bus.mode_lp} !== 3'b000) begin errors++; $display("FAIL rsta_ctl got busy %b read %b mode %b exp 0 0 0", bus.busy, bus.fifo_read, bus.mode_lp); end
    checks++; if (bus.start_rqst !== '0 || bus.fin_rqst !== '0) begin errors++; $display("FAIL rsta_req got start %h fin %h exp 0 0", bus.start_rqst, bus.fin_rqst); end
    checks++; if (bus.inp_data !== '0) begin errors++; $display("FAIL rsta_data got %h exp 0", bus.inp_data); end
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL rsta_rel_read got %b exp 1", bus.fifo_read); end
    step(1'b0);
    checks++; if (bus.start_rqst !== ALL) begin errors++; $display("FAIL rsta_start got %h exp %h", bus.start_rqst, ALL); end
    sb_pop();
    checks++; if (bus.inp_data !== e.d || bus.mode_lp !== e.m) begin errors++; $display("FAIL rsta_word got %h/%b exp %h/%b", bus.inp_data, bus.mode_lp, e.d, e.m); end
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL rsta_finish got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
  endtask

  task automatic test_reset_gap();
    bus.p2p_timeout = TW'(3);
    push(32'h000000A5, 3'd1, 1'b0);
    push(32'h5A5A5A5A, 3'd4, 1'b0);
    #1;
    step(1'b0);
    sb_pop();
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== 4'b0001) begin errors++; $display("FAIL rstg_finish got %b exp 0001", bus.fin_rqst); end
    step(1'b0);
    checks++; if (bus.busy !== 1'b1 || bus.fifo_read !== 1'b0) begin errors++; $display("FAIL rstg_gap got busy %b read %b exp 1 0", bus.busy, bus.fifo_read); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.fin_rqst !== '0) begin errors++; $display("FAIL rstg_rst got busy %b fin %h exp 0 0", bus.busy, bus.fin_rqst); end
    step(1'b0);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL rstg_rel_read got %b exp 1", bus.fifo_read); end
    step(1'b0);
    sb_pop();
    checks++; if (bus.inp_data !== e.d) begin errors++; $display("FAIL rstg_word got %h exp %h", bus.inp_data, e.d); end
    bus.p2p_timeout = '0;
    step(1'b1);
    step(1'b0);
    checks++; if (bus.fin_rqst !== ALL) begin errors++; $display("FAIL rstg_finish2 got %h exp %h", bus.fin_rqst, ALL); end
    step(1'b0);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.data_rqst   = 1'b0;
    bus.p2p_timeout = '0;
    bus.fifo_data   = '0;
    bus.fifo_bytes  = '0;
    bus.fifo_empty  = 1'b1;
    bus.mode_lp_in  = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_short();
    test_gap();
    test_mode();
    test_reset_active();
    test_reset_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
